// File: rtl/sample_serializer.sv
// Parallel-to-serial stage: captures one N_SAMPLES-word frame in a single transfer,
// then streams it out word 0 first over a val/rdy handshake.
module sample_serializer #(
   parameter int BIT_WIDTH = 32,
   parameter int N_SAMPLES = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           in_val,
   output logic                           in_rdy,
   input  logic [N_SAMPLES*BIT_WIDTH-1:0] in_msg,
   output logic                           out_val,
   input  logic                           out_rdy,
   output logic [BIT_WIDTH-1:0]           out_msg,
   output logic                           out_last
);

   localparam int IW = $clog2(N_SAMPLES);
   localparam logic [IW-1:0] LAST_IDX = IW'(N_SAMPLES - 1);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [IW-1:0]        index_q, index_d;
   logic [BIT_WIDTH-1:0] bank_q [N_SAMPLES];
   logic                 capture;

   assign capture = (state_q == IDLE) && in_val;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         index_q <= '0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
      end
   end

   // The bank only loads in IDLE, so a frame in flight can never be overwritten.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < N_SAMPLES; k++) begin
            bank_q[k] <= '0;
         end
      end else if (capture) begin
         for (int k = 0; k < N_SAMPLES; k++) begin
            bank_q[k] <= in_msg[k*BIT_WIDTH +: BIT_WIDTH];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      index_d = index_q;
      case (state_q)
         IDLE: begin
            index_d = '0;
            if (in_val) begin
               state_d = SEND;
            end
         end
         SEND: begin
            if (out_rdy) begin
               if (index_q == LAST_IDX) begin
                  index_d = '0;
                  state_d = IDLE;
               end else begin
                  index_d = index_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            index_d = '0;
         end
      endcase
   end

   // Outputs depend on registered state only; index is 0 in IDLE so out_msg shows bank[0].
   assign in_rdy   = (state_q == IDLE);
   assign out_val  = (state_q == SEND);
   assign out_msg  = bank_q[index_q];
   assign out_last = (state_q == SEND) && (index_q == LAST_IDX);

endmodule

// File: tb/tb_sample_serializer.sv
// Bench for sample_serializer: directed vector table, hand sequences for the
// multi-cycle corners, and random traffic checked against a word-queue model.
module tb_sample_serializer;

   localparam int W = 32;
   localparam int N = 8;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           in_val = 1'b0;
   logic           in_rdy;
   logic [N*W-1:0] in_msg = '0;
   logic           out_val;
   logic           out_rdy = 1'b0;
   logic [W-1:0]   out_msg;
   logic           out_last;

   always #5 clk = ~clk;

   sample_serializer #(.BIT_WIDTH(W), .N_SAMPLES(N)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_val   (in_val),
      .in_rdy   (in_rdy),
      .in_msg   (in_msg),
      .out_val  (out_val),
      .out_rdy  (out_rdy),
      .out_msg  (out_msg),
      .out_last (out_last)
   );

   typedef struct {
      logic         in_val;
      logic         out_rdy;
      logic         exp_in_rdy;
      logic         exp_out_val;
      logic [W-1:0] exp_msg;
      logic         exp_last;
   } vec_t;

   vec_t vecs[$];

   int errors = 0;
   int checks = 0;

   // Reference model: words still owed to the downstream, plus word 0 of the last frame.
   logic [W-1:0] exp_q[$];
   logic [W-1:0] last_w0 = '0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add_vec(input logic v, input logic r, input logic ir, input logic ov,
                          input logic [W-1:0] m, input logic l);
      vec_t e;
      e.in_val = v; e.out_rdy = r; e.exp_in_rdy = ir;
      e.exp_out_val = ov; e.exp_msg = m; e.exp_last = l;
      vecs.push_back(e);
   endtask

   function automatic logic [N*W-1:0] ramp_frame(input logic [W-1:0] base);
      logic [N*W-1:0] f;
      for (int k = 0; k < N; k++) f[k*W +: W] = base + W'(k);
      return f;
   endfunction

   function automatic logic [N*W-1:0] rand_frame();
      logic [N*W-1:0] f;
      for (int k = 0; k < N; k++) f[k*W +: W] = $urandom;
      return f;
   endfunction

   // One cycle: drive at negedge, check against the model, then advance the model
   // to what the next posedge must do.
   task automatic step(input logic v, input logic [N*W-1:0] m, input logic r);
      @(negedge clk);
      in_val = v; in_msg = m; out_rdy = r;
      #1;
      if (exp_q.size() == 0) begin
         chk("idle_in_rdy", W'(in_rdy), 1);
         chk("idle_out_val", W'(out_val), 0);
         chk("idle_out_last", W'(out_last), 0);
         chk("idle_out_msg", out_msg, last_w0);
         if (v) begin
            for (int k = 0; k < N; k++) exp_q.push_back(m[k*W +: W]);
            last_w0 = m[W-1:0];
            $display("capture frame word0=%h", m[W-1:0]);
         end
      end else begin
         chk("send_in_rdy", W'(in_rdy), 0);
         chk("send_out_val", W'(out_val), 1);
         chk("send_out_last", W'(out_last), W'(exp_q.size() == 1));
         chk("send_out_msg", out_msg, exp_q[0]);
         if (r) begin
            $display("word %h last=%0d", exp_q[0], exp_q.size() == 1);
            void'(exp_q.pop_front());
         end
      end
   endtask

   logic [N*W-1:0] frame_a;
   logic [N*W-1:0] frame_b;
   logic [N*W-1:0] frame_c;

   initial begin
      frame_a = ramp_frame(32'hA0);
      frame_b = ramp_frame(32'hB0);
      frame_c = ramp_frame(32'hC0);

      // Directed table: reset state, plain frame, out_rdy ignored in IDLE, backpressure on word 2.
      add_vec(0, 0, 1, 0, 32'h0, 0);
      add_vec(1, 1, 1, 0, 32'h0, 0);
      for (int k = 0; k < N; k++) add_vec(0, 1, 0, 1, 32'hA0 + k, k == N-1);
      add_vec(1, 0, 1, 0, 32'hA0, 0);
      add_vec(0, 1, 0, 1, 32'hA0, 0);
      add_vec(0, 1, 0, 1, 32'hA1, 0);
      for (int k = 0; k < 3; k++) add_vec(0, 0, 0, 1, 32'hA2, 0);
      for (int k = 2; k < N; k++) add_vec(0, 1, 0, 1, 32'hA0 + k, k == N-1);
      add_vec(0, 1, 1, 0, 32'hA0, 0);

      // Asynchronous reset: outputs must settle before any clock edge.
      #2 reset = 1'b0;
      #1;
      chk("rst_in_rdy", W'(in_rdy), 1);
      chk("rst_out_val", W'(out_val), 0);
      chk("rst_out_msg", out_msg, 0);
      chk("rst_out_last", W'(out_last), 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         in_val = vecs[i].in_val; in_msg = frame_a; out_rdy = vecs[i].out_rdy;
         #1;
         chk($sformatf("vec%0d_in_rdy", i), W'(in_rdy), W'(vecs[i].exp_in_rdy));
         chk($sformatf("vec%0d_out_val", i), W'(out_val), W'(vecs[i].exp_out_val));
         chk($sformatf("vec%0d_out_msg", i), out_msg, vecs[i].exp_msg);
         chk($sformatf("vec%0d_out_last", i), W'(out_last), W'(vecs[i].exp_last));
      end
      last_w0 = 32'hA0;

      // Frame offered while busy is ignored, then captured in the first IDLE cycle.
      step(1, frame_a, 1);
      for (int k = 0; k < N; k++) step(1, frame_b, 1);
      step(1, frame_b, 1);
      chk("busy_frame_captured", W'(exp_q.size()), N);

      // Back-to-back frames with in_val and out_rdy held high.
      for (int k = 0; k < N; k++) step(1, frame_c, 1);
      for (int k = 0; k < 2*(N+1); k++) step(1, (k < N+1) ? frame_c : frame_a, 1);

      // Reset after word 4 handshake: remaining words are dropped.
      while (exp_q.size() != 0) step(0, frame_a, 1);
      step(1, frame_b, 1);
      for (int k = 0; k < 5; k++) step(0, frame_b, 1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("midrst_in_rdy", W'(in_rdy), 1);
      chk("midrst_out_val", W'(out_val), 0);
      chk("midrst_out_msg", out_msg, 0);
      chk("midrst_out_last", W'(out_last), 0);
      exp_q.delete();
      last_w0 = '0;
      @(negedge clk);
      reset = 1'b1;
      step(1, frame_c, 1);
      for (int k = 0; k < N; k++) step(0, frame_c, 1);

      // Random traffic against the model.
      for (int k = 0; k < 600; k++) begin
         step(1'($urandom_range(0, 1)), rand_frame(), 1'($urandom_range(0, 3) != 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
